distance_filter: RTL and testbench



---
 rtl/distance_filter_pkg.sv | 11 +
 rtl/dist_window.sv | 53 +++++
 rtl/distance_filter.sv | 98 +++++++++
 tb/tb_distance_filter.sv | 108 ++++++++++
 4 files changed

// File: rtl/distance_filter_pkg.sv
// distance_filter_pkg: definitions shared by the ranger, filter and display logic
//   DIST_W      distance word width in cm
//   *_DEF       default acceptance limit and hysteresis thresholds
//   state_t     filter FSM encoding (S_FILL=01, S_RUN=10)
package distance_filter_pkg;
   localparam int unsigned DIST_W       = 12;
   localparam int unsigned MAX_CM_DEF   = 400;
   localparam int unsigned NEAR_ON_DEF  = 10;
   localparam int unsigned NEAR_OFF_DEF = 15;
   typedef enum logic [1:0] {S_FILL = 2'b01, S_RUN = 2'b10} state_t;
endpackage

// File: rtl/dist_window.sv
// dist_window: circular sample buffer with running sum
//   clk, reset_n  clock and synchronous active-low reset
//   push          write din at the write pointer and advance it
//   clear         zero all entries, the sum, the fill count and the pointer
//   din           sample to write
//   sum           running sum as it stands after this cycle's push/clear
//   full          window holds W samples after this cycle's push/clear
module dist_window
   import distance_filter_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       clear,
   input  logic [DIST_W-1:0]          din,
   output logic [DIST_W+WIN_LOG2-1:0] sum,
   output logic                       full
);
   localparam int unsigned W  = 1 << WIN_LOG2;
   localparam int unsigned SW = DIST_W + WIN_LOG2;
   localparam logic [WIN_LOG2:0] FULL_CNT = W[WIN_LOG2:0];
   logic [DIST_W-1:0]   ent_q [W];
   logic [WIN_LOG2-1:0] wr_q;
   logic [SW-1:0]       sum_q, sum_d;
   logic [WIN_LOG2:0]   cnt_q, cnt_d;
   // Next-state values are exported so the top can act on the post-push sum in the same cycle.
   always_comb begin
      sum_d = clear ? '0 : push ? sum_q - SW'(ent_q[wr_q]) + SW'(din) : sum_q;
      cnt_d = clear ? '0 : (push && cnt_q != FULL_CNT) ? cnt_q + 1'b1 : cnt_q;
   end
   assign sum  = sum_d;
   assign full = cnt_d == FULL_CNT;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ent_q <= '{default: '0};
         wr_q  <= '0;
         sum_q <= '0;
         cnt_q <= '0;
      end else begin
         if (clear) begin
            ent_q <= '{default: '0};
            wr_q  <= '0;
         end else if (push) begin
            ent_q[wr_q] <= din;
            wr_q        <= wr_q + 1'b1;
         end
         sum_q <= sum_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/distance_filter.sv
// distance_filter: range check, moving average, hysteretic near flag and stale timeout
//   clk, reset_n  clock and synchronous active-low reset
//   dist_in       distance in cm, qualified by dist_valid
//   dist_avg      windowed average, updated with the avg_valid strobe
//   avg_valid     one-cycle strobe, dist_avg updated
//   near          proximity flag with hysteresis
//   stale         no accepted sample within TIMEOUT_CYC cycles
//   reject        one-cycle strobe, sample discarded
//   state_dbg     current FSM state
module distance_filter
   import distance_filter_pkg::*;
#(
   parameter int unsigned WIN_LOG2    = 2,
   parameter int unsigned MAX_CM      = MAX_CM_DEF,
   parameter int unsigned NEAR_ON     = NEAR_ON_DEF,
   parameter int unsigned NEAR_OFF    = NEAR_OFF_DEF,
   parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DIST_W-1:0] dist_in,
   input  logic              dist_valid,
   output logic [DIST_W-1:0] dist_avg,
   output logic              avg_valid,
   output logic              near,
   output logic              stale,
   output logic              reject,
   output logic [1:0]        state_dbg
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   state_t                     state_q, state_d;
   logic [DIST_W-1:0]          avg_q, avg_d, avg_new;
   logic                       av_q, av_d, near_q, near_d, stale_q, stale_d, rej_q, rej_d;
   logic [TW-1:0]              tmo_q, tmo_d;
   logic                       accept, expire, full;
   logic [DIST_W+WIN_LOG2-1:0] sum;
   assign accept  = dist_valid && dist_in != '0 && dist_in <= DIST_W'(MAX_CM);
   // An accepted sample beats expiry; once stale, the saturated counter must not fire again.
   assign expire  = !accept && !stale_q && tmo_q == TMO_LAST;
   assign avg_new = DIST_W'(sum >> WIN_LOG2);
   dist_window #(.WIN_LOG2(WIN_LOG2)) u_win (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .clear   (expire),
      .din     (dist_in),
      .sum     (sum),
      .full    (full)
   );
   always_comb begin
      state_d = state_q;
      avg_d   = avg_q;
      av_d    = 1'b0;
      near_d  = near_q;
      stale_d = stale_q;
      rej_d   = dist_valid && !accept;
      tmo_d   = accept ? '0 : (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
      if (accept) begin
         stale_d = 1'b0;
         if (state_q == S_RUN || full) begin
            state_d = S_RUN;
            av_d    = 1'b1;
            avg_d   = avg_new;
            near_d  = avg_new < DIST_W'(NEAR_ON) ? 1'b1 : avg_new > DIST_W'(NEAR_OFF) ? 1'b0 : near_q;
         end
      end else if (expire) begin
         stale_d = 1'b1;
         near_d  = 1'b0;
         state_d = S_FILL;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_FILL;
         avg_q   <= '0;
         av_q    <= 1'b0;
         near_q  <= 1'b0;
         stale_q <= 1'b0;
         rej_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         avg_q   <= avg_d;
         av_q    <= av_d;
         near_q  <= near_d;
         stale_q <= stale_d;
         rej_q   <= rej_d;
         tmo_q   <= tmo_d;
      end
   end
   assign dist_avg  = avg_q;
   assign avg_valid = av_q;
   assign near      = near_q;
   assign stale     = stale_q;
   assign reject    = rej_q;
   assign state_dbg = state_q;
endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter: directed self-checking bench for distance_filter (W=4, timeout 1000 cycles)
module tb_distance_filter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] dist_in = '0;
   logic        dist_valid = 1'b0;
   logic [11:0] dist_avg;
   logic        avg_valid, near, stale, reject;
   logic [1:0]  state_dbg;
   int n_asrt = 0;
   int n_fail = 0;

   distance_filter #(.WIN_LOG2(2), .MAX_CM(400), .NEAR_ON(10), .NEAR_OFF(15), .TIMEOUT_CYC(1000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dist_in    (dist_in),
      .dist_valid (dist_valid),
      .dist_avg   (dist_avg),
      .avg_valid  (avg_valid),
      .near       (near),
      .stale      (stale),
      .reject     (reject),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [11:0] d);
      dist_in = d;
      dist_valid = 1'b1;
      @(posedge clk);
      #1;
      dist_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      idle(2);
      chk("rst_avg", dist_avg, 0);
      chk("rst_av", avg_valid, 0);
      chk("rst_near", near, 0);
      chk("rst_stale", stale, 0);
      chk("rst_reject", reject, 0);
      chk("rst_state", state_dbg, 2'b01);
      reset_n = 1'b1;
      idle(1);
      send(20); chk("fill1_av", avg_valid, 0);
      send(22); chk("fill2_av", avg_valid, 0);
      send(24); chk("fill3_av", avg_valid, 0); chk("fill3_state", state_dbg, 2'b01);
      send(26); chk("fill4_av", avg_valid, 1); chk("fill4_avg", dist_avg, 23);
      chk("fill4_state", state_dbg, 2'b10);
      idle(1); chk("hold_av", avg_valid, 0); chk("hold_avg", dist_avg, 23);
      send(30); chk("run_av", avg_valid, 1); chk("run_avg", dist_avg, 25);
      chk("run_state", state_dbg, 2'b10); chk("run_near", near, 0);
      send(8); send(8); send(8); chk("h8_3_avg", dist_avg, 13); chk("h8_3_near", near, 0);
      send(8); chk("h8_avg", dist_avg, 8); chk("h8_near", near, 1);
      send(12); chk("h12_1_avg", dist_avg, 9);
      send(12); send(12); send(12); chk("h12_avg", dist_avg, 12); chk("h12_near", near, 1);
      send(20); send(20); chk("h20_2_avg", dist_avg, 16); chk("h20_2_near", near, 0);
      send(20); send(20); chk("h20_avg", dist_avg, 20); chk("h20_near", near, 0);
      send(0); chk("rej0", reject, 1); chk("rej0_av", avg_valid, 0);
      send(450); chk("rej450", reject, 1); chk("rej450_av", avg_valid, 0);
      idle(1); chk("rej_clear", reject, 0);
      send(28); chk("post_rej_av", avg_valid, 1); chk("post_rej_avg", dist_avg, 22);
      chk("post_rej_reject", reject, 0);
      send(400); chk("max_reject", reject, 0); chk("max_avg", dist_avg, 117);
      send(401); chk("over_reject", reject, 1); chk("over_av", avg_valid, 0);
      send(1); chk("min_reject", reject, 0); chk("min_avg", dist_avg, 112);
      send(5); send(5); send(5); chk("n5_3_near", near, 1);
      send(5); chk("n5_avg", dist_avg, 5); chk("n5_near", near, 1);
      idle(999); chk("pre_stale", stale, 0); chk("pre_stale_near", near, 1);
      idle(1); chk("stale_set", stale, 1); chk("stale_near", near, 0);
      chk("stale_state", state_dbg, 2'b01); chk("stale_avg", dist_avg, 5);
      chk("stale_av", avg_valid, 0);
      idle(5); chk("stale_held", stale, 1);
      send(50); chk("refill1_stale", stale, 0); chk("refill1_av", avg_valid, 0);
      send(50); send(50); chk("refill3_av", avg_valid, 0); chk("refill3_state", state_dbg, 2'b01);
      send(50); chk("refill4_av", avg_valid, 1); chk("refill4_avg", dist_avg, 50);
      chk("refill4_state", state_dbg, 2'b10);
      idle(999); chk("edge_pre", stale, 0);
      send(60); chk("edge_stale", stale, 0); chk("edge_av", avg_valid, 1);
      chk("edge_avg", dist_avg, 52);
      idle(10); chk("edge_after", stale, 0); chk("edge_after_state", state_dbg, 2'b10);
      send(5); send(5); send(5); send(5); chk("pre_rst_near", near, 1);
      reset_n = 1'b0; dist_in = 0; dist_valid = 1'b1;
      idle(1);
      chk("mid_rst_avg", dist_avg, 0); chk("mid_rst_near", near, 0);
      chk("mid_rst_state", state_dbg, 2'b01); chk("mid_rst_reject", reject, 0);
      chk("mid_rst_stale", stale, 0); chk("mid_rst_av", avg_valid, 0);
      reset_n = 1'b1; dist_valid = 1'b0;
      send(100); send(100); send(100); chk("post_rst3_av", avg_valid, 0);
      send(100); chk("post_rst4_av", avg_valid, 1); chk("post_rst4_avg", dist_avg, 100);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
